seq_mac_multiplier: RTL and testbench
=====================================

# seq_mac_multiplier

Iterative shift-add multiplier/accumulator for the kernel-calculation datapath of the downsampling processor. It is the parametrised successor to the combinational 8x8 multiplier. It computes one partial product per clock, using a valid/ready handshake on both sides. An optional accumulate mode adds each new product onto the previous result, so kernel dot-products can be formed without an external adder.

## Interface
- `WIDTH`, default 8: operand width in bits, must be ≥ 2.
- `GUARD`, default 4: accumulator guard bits; result width is `PW = 2*WIDTH + GUARD`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands and `acc_en` are valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `multiplier`  in  WIDTH  multiplier operand.
- `multiplicand`  in  WIDTH  multiplicand operand.
- `acc_en`  in  1  sampled at accept: 1 adds the product to the held result, 0 starts the result from zero.
- `out_valid`  out  1  `product` is final.
- `out_ready`  in  1  downstream consumes `product`.
- `product`  out  PW  result or accumulator register.
- `busy`  out  1  high in CALC or DONE.

## Operation
- Three states: IDLE, CALC, DONE.
- IDLE, with `in_ready`=1:
  - On `in_valid`, latch `multiplier` into `mr`, latch `multiplicand` extended to PW into `md`, and set `cnt`=0.
  - If `acc_en`=0, clear `product`; if `acc_en`=1, keep it.
  - Go to CALC.
- CALC, one step per cycle:
  - If `mr[cnt]`=1, add `md << cnt` to `product`; otherwise hold.
  - Increment `cnt`.
  - When `cnt`=WIDTH-1 completes, go to DONE.
- DONE: `out_valid`=1. `product` holds stable until `out_ready`=1, then go to IDLE.
- Arithmetic is modulo 2^PW. Accumulator overflow wraps silently; there is no saturation or flag.
- The only input sampling points are the operands and `acc_en` at accept. Operand changes afterwards have no effect.
- `in_valid` asserted outside IDLE is ignored, and `in_ready`=0 there.
- `out_ready` asserted outside DONE is ignored.
- `product` stays readable in IDLE and equals the last result. It is valid for accumulation but `out_valid`=0.

## Timing
- Reset values: state IDLE, `product`=0, `out_valid`=0, `in_ready`=1, `busy`=0, `cnt`=0.
- Reset asserted mid-operation aborts immediately: `product` goes to 0 and the accumulator is lost.
- Accept edge T. CALC spans edges T+1 through T+WIDTH. `out_valid` is high after edge T+WIDTH.
- Latency is exactly WIDTH cycles from accept to `out_valid`, independent of operand values.
- Fastest back-to-back period is WIDTH+2 cycles: accept, WIDTH steps, output handshake, then the next accept.
- `in_ready`, `out_valid` and `busy` decode directly from the state register and have no combinational path from inputs.

## Configuration
- Macro `SEQ_MULT_SIGNED_EN`.
- Defined: operands are two's complement.
  - `md` is sign-extended to PW.
  - The final step (`cnt`=WIDTH-1) subtracts `md << (WIDTH-1)` when `mr[WIDTH-1]`=1.
  - `product` is a signed PW-bit value.
- Undefined: operands are unsigned, `md` is zero-extended, and every step adds.
- Latency and handshake are identical in both builds.

## Structure
- Package `seq_mult_pkg`:
  - state enum (IDLE/CALC/DONE);
  - `PW` derivation helper;
  - counter width `$clog2(WIDTH)`.
- Sub-module `mult_step`: combinational unit that computes `product ± (md << cnt)`, with the subtract select driven only in the signed build.
- The top level holds the FSM, `mr`/`md`/`cnt` registers and the handshake.

## Test plan
1. Unsigned, WIDTH=8: accept 13×11 with `acc_en`=0 → `out_valid` exactly 8 cycles after accept, `product`=143.
2. Unsigned: 255×255 → 65025; then 0×200 → 0, still taking 8 cycles.
3. Accumulate: 3×4 with `acc_en`=0 → 12; then 5×6 with `acc_en`=1 → 42; then 2×2 with `acc_en`=0 → 4.
4. Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `product` stable, `in_ready`=0, concurrent `in_valid` ignored; release → IDLE one cycle later.
5. Reset: assert `rst_n`=0 at the 4th CALC cycle → `out_valid`=0, `product`=0 immediately; after release, `in_ready`=1 and 7×7 yields 49.
6. With `SEQ_MULT_SIGNED_EN`:
   - −3×5 → `product`=20'hFFFF1 (−15);
   - −128×−128 → 16384;
   - accumulate 127×−1 onto 1 → −126.

Source files
------------

// File: rtl/seq_mult_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mult_pkg: shared types and sizing helpers for seq_mac_multiplier |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_pw(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  function automatic int calc_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_step.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_step: one shift-add partial-product step, acc +/- (md << shift) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mult_step #(
  parameter int PW = 20,
  parameter int CW = 3
) (
  input  logic [PW-1:0] acc,
  input  logic [PW-1:0] md,
  input  logic [CW-1:0] shift,
  input  logic          add_en,
  input  logic          sub,
  output logic [PW-1:0] result
);

  logic [PW-1:0] addend;

  always_comb begin
    addend = md << shift;
    result = acc;
    if (add_en) begin
      result = sub ? (acc - addend) : (acc + addend);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_mac_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mac_multiplier: iterative shift-add multiply/accumulate with     |
// | valid/ready handshakes. Define SEQ_MULT_SIGNED_EN for two's          |
// | complement operands. Rev 1.0                                         |
// +----------------------------------------------------------------------+
module seq_mac_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           multiplier,
  input  logic [WIDTH-1:0]           multiplicand,
  input  logic                       acc_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH+GUARD-1:0]   product,
  output logic                       busy
);

  localparam int PW = calc_pw(WIDTH, GUARD);
  localparam int CW = calc_cnt_w(WIDTH);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  mr;
  logic [PW-1:0]     md;
  logic [PW-1:0]     md_ext;
  logic [CW-1:0]     cnt;
  logic              last_step;
  logic              sub;
  logic [PW-1:0]     step_result;

  assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  assign md_ext = {{(PW - WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
  // The MSB of a two's complement multiplier carries negative weight.
  assign sub    = last_step;
`else
  assign md_ext = {{(PW - WIDTH){1'b0}}, multiplicand};
  assign sub    = 1'b0;
`endif

  mult_step #(
    .PW (PW),
    .CW (CW)
  ) u_step (
    .acc    (product),
    .md     (md),
    .shift  (cnt),
    .add_en (mr[cnt]),
    .sub    (sub),
    .result (step_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr      <= '0;
      md      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mr  <= multiplier;
            md  <= md_ext;
            cnt <= '0;
            if (!acc_en) product <= '0;
          end
        end
        CALC: begin
          product <= step_result;
          cnt     <= last_step ? '0 : cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mac_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_mac_multiplier: directed vector bench for seq_mac_multiplier  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_mac_multiplier;

  localparam int WIDTH = 8;
  localparam int GUARD = 4;
  localparam int PW    = 2 * WIDTH + GUARD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] multiplier = '0;
  logic [WIDTH-1:0] multiplicand = '0;
  logic             acc_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PW-1:0]    product;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] mr;
    logic [WIDTH-1:0] md;
    logic             acc;
    logic [PW-1:0]    exp;
  } vec_t;

  vec_t vecs[$];

  seq_mac_multiplier #(
    .WIDTH (WIDTH),
    .GUARD (GUARD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .acc_en       (acc_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full transaction; operands are scrambled after accept to prove they are not resampled.
  task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic acc, input logic [PW-1:0] exp);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    multiplier   = a;
    multiplicand = b;
    acc_en       = acc;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    multiplier   = ~a;
    multiplicand = 8'h5A;
    acc_en       = ~acc;
    check({name, " busy in calc"}, {30'd0, busy, in_ready}, 32'd2);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(WIDTH));
    check({name, " product"}, 32'(product), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " back to idle"}, {29'd0, busy, in_ready, out_valid}, 32'd2);
    check({name, " product held in idle"}, 32'(product), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [PW-1:0] held;

`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{8'hFD, 8'd5,   1'b0, 20'hFFFF1});
    vecs.push_back('{8'h80, 8'h80,  1'b0, 20'd16384});
    vecs.push_back('{8'd1,  8'd1,   1'b0, 20'd1});
    vecs.push_back('{8'd127, 8'hFF, 1'b1, 20'hFFF82});
    vecs.push_back('{8'd5,  8'hFE,  1'b0, 20'hFFFF6});
`else
    vecs.push_back('{8'd13,  8'd11,  1'b0, 20'd143});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 20'd65025});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 20'd0});
    vecs.push_back('{8'd3,   8'd4,   1'b0, 20'd12});
    vecs.push_back('{8'd5,   8'd6,   1'b1, 20'd42});
    vecs.push_back('{8'd2,   8'd2,   1'b0, 20'd4});
    vecs.push_back('{8'd200, 8'd100, 1'b1, 20'd20004});
`endif

    #12;
    check("reset product", 32'(product), 32'd0);
    check("reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].mr, vecs[i].md, vecs[i].acc, vecs[i].exp);
    end

    // Backpressure: result holds and new requests are ignored while DONE.
    multiplier = 8'd9; multiplicand = 8'd9; acc_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", 32'(cyc), 32'(WIDTH));
    held = product;
    check("bp product", 32'(held), 32'd81);
    multiplier = 8'd3; multiplicand = 8'd7; acc_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold product c%0d", k), 32'(product), 32'd81);
      check($sformatf("bp hold flags c%0d", k), {29'd0, in_ready, out_valid, busy}, 32'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    do_op("bp after", 8'd3, 8'd3, 1'b1, 20'd90);

    // Reset mid-calculation discards the accumulator.
    multiplier = 8'd5; multiplicand = 8'd5; acc_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset product", 32'(product), 32'd0);
    check("mid reset flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post reset 7x7 acc", 8'd7, 8'd7, 1'b1, 20'd49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
